// File: rtl/vec_exec_seq.sv
// Multi-cycle execution sequencer: drives a shared 4-lane ALU in 64-bit beats and
// assembles a 256-bit vector result, a 16-bit VDOT scalar or an immediate result.
module vec_exec_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   functype,
    input  logic [255:0] op1,
    input  logic [255:0] op2,
    output logic         busy,
    output logic         alu_valid,
    output logic [1:0]   alu_mode,
    output logic [63:0]  alu_a,
    output logic [63:0]  alu_b,
    input  logic         alu_rvalid,
    input  logic [63:0]  alu_result,
    output logic         done,
    output logic [255:0] result,
    output logic         illegal
);
    localparam logic [3:0] FT_VADD = 4'b0000;
    localparam logic [3:0] FT_VDOT = 4'b0001;
    localparam logic [3:0] FT_SMUL = 4'b0010;
    localparam logic [3:0] FT_SST  = 4'b0011;
    localparam logic [3:0] FT_VLD  = 4'b0100;
    localparam logic [3:0] FT_VST  = 4'b0101;
    localparam logic [3:0] FT_SLL  = 4'b0110;
    localparam logic [3:0] FT_SLH  = 4'b0111;
    localparam logic [3:0] FT_NOP  = 4'b1111;
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_MUL = 2'b01;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t         state_r, next_state_s;
    logic [3:0]     func_r;
    logic [255:0]   op1_r, op2_r;
    logic [15:0]    acc_r;
    logic [1:0]     beat_r;

    logic [3:0]     src_func_s;
    logic [255:0]   src_op1_s, src_op2_s;
    logic [1:0]     issue_beat_s;
    logic [63:0]    issue_a_s, issue_b_s;
    logic [1:0]     issue_mode_s;
    logic           last_beat_s;
    logic           capture_s;
    logic [15:0]    vdot_sum_s;

    function automatic logic is_alu_op(input logic [3:0] f);
        case (f)
            FT_VADD, FT_VDOT, FT_SMUL, FT_VLD, FT_VST: is_alu_op = 1'b1;
            default:                                   is_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [3:0] f);
        case (f)
            FT_VADD, FT_VDOT, FT_SMUL, FT_SST, FT_VLD, FT_VST,
            FT_SLL, FT_SLH, FT_NOP: is_illegal = 1'b0;
            default:                is_illegal = 1'b1;
        endcase
    endfunction

    // Result known at issue time for ops that never touch the ALU.
    function automatic logic [255:0] imm_result(input logic [3:0] f,
                                                input logic [255:0] a,
                                                input logic [255:0] b);
        case (f)
            FT_SLL:  imm_result = {240'd0, a[15:8], b[7:0]};
            FT_SLH:  imm_result = {240'd0, b[7:0], a[7:0]};
            default: imm_result = 256'd0;
        endcase
    endfunction

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = is_alu_op(functype) ? ST_ISSUE : ST_DONE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (alu_rvalid) begin
                    next_state_s = last_beat_s ? ST_DONE : ST_ISSUE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Beat operands are prepared one cycle ahead so the ALU request leaves a register;
    // in IDLE the live inputs are used because capture happens on the same edge.
    always_comb begin
        src_func_s   = (state_r == ST_IDLE) ? functype : func_r;
        src_op1_s    = (state_r == ST_IDLE) ? op1 : op1_r;
        src_op2_s    = (state_r == ST_IDLE) ? op2 : op2_r;
        issue_beat_s = (state_r == ST_WAIT) ? (beat_r + 2'd1) : 2'd0;
        issue_b_s    = src_op2_s[{issue_beat_s, 6'd0} +: 64];
        if (src_func_s == FT_SMUL) begin
            issue_a_s = {4{src_op1_s[15:0]}};
        end else begin
            issue_a_s = src_op1_s[{issue_beat_s, 6'd0} +: 64];
        end
        if (src_func_s == FT_VDOT || src_func_s == FT_SMUL) begin
            issue_mode_s = MODE_MUL;
        end else begin
            issue_mode_s = MODE_ADD;
        end
        last_beat_s = (func_r == FT_VLD) || (func_r == FT_VST) || (beat_r == 2'd3);
        capture_s   = (state_r == ST_WAIT) && alu_rvalid;
        vdot_sum_s  = acc_r + alu_result[15:0] + alu_result[31:16]
                            + alu_result[47:32] + alu_result[63:48];
    end

    // State, registered outputs, operand capture and per-beat result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            alu_valid <= 1'b0;
            alu_mode  <= 2'd0;
            alu_a     <= 64'd0;
            alu_b     <= 64'd0;
            illegal   <= 1'b0;
            result    <= 256'd0;
            func_r    <= 4'd0;
            op1_r     <= 256'd0;
            op2_r     <= 256'd0;
            acc_r     <= 16'd0;
            beat_r    <= 2'd0;
        end else begin
            state_r   <= next_state_s;
            busy      <= (next_state_s != ST_IDLE);
            done      <= (next_state_s == ST_DONE);
            alu_valid <= (next_state_s == ST_ISSUE);
            if (next_state_s == ST_ISSUE) begin
                alu_mode <= issue_mode_s;
                alu_a    <= issue_a_s;
                alu_b    <= issue_b_s;
            end else begin
                alu_mode <= 2'd0;
                alu_a    <= 64'd0;
                alu_b    <= 64'd0;
            end
            if (state_r == ST_IDLE && start) begin
                func_r  <= functype;
                op1_r   <= op1;
                op2_r   <= op2;
                acc_r   <= 16'd0;
                beat_r  <= 2'd0;
                illegal <= is_illegal(functype);
                result  <= imm_result(functype, op1, op2);
            end else if (capture_s) begin
                beat_r <= beat_r + 2'd1;
                case (func_r)
                    FT_VADD, FT_SMUL: result[{beat_r, 6'd0} +: 64] <= alu_result;
                    FT_VDOT: begin
                        acc_r  <= vdot_sum_s;
                        result <= {240'd0, vdot_sum_s};
                    end
                    FT_VLD, FT_VST: result <= {240'd0, alu_result[15:0]};
                    default: result <= result;
                endcase
            end
        end
    end
endmodule

// File: doc/vec_exec_seq.md
# vec_exec_seq

Multi-cycle execution sequencer between the operand picker and the shared 4-lane ALU.
- Captures the two 256-bit operands and the function type on an accepted start.
- Issues the operation to the ALU as up to four 64-bit beats, waits for each beat's result, assembles the 256-bit vector result or reduces it to a 16-bit scalar for VDOT, and signals completion.
- One instruction in flight at a time; the decode stage stalls on `busy`.

## Interface
Parameters:
- none. Fixed geometry: 16 lanes × 16 bits, 4 lanes per beat, 4 beats.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe; accepted only when `busy`=0.
- `functype`  in  4  opcode: VADD=0000, VDOT=0001, SMUL=0010, SST=0011, VLD=0100, VST=0101, SLL=0110, SLH=0111, NOP=1111.
- `op1`  in  256  operand 1 from picker; lane i = bits [16i+15:16i].
- `op2`  in  256  operand 2 from picker.
- `busy`  out  1  high from the cycle after an accepted start through the done cycle.
- `alu_valid`  out  1  one-cycle beat request to the shared ALU.
- `alu_mode`  out  2  00=ADD, 01=MUL (low 16 bits of product), others unused.
- `alu_a`  out  64  beat operand A, 4 lanes.
- `alu_b`  out  64  beat operand B, 4 lanes.
- `alu_rvalid`  in  1  beat result strobe; earliest one cycle after `alu_valid`.
- `alu_result`  in  64  beat result, sampled when `alu_rvalid`=1.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  256  instruction result; valid from `done` until the next accepted start.
- `illegal`  out  1  qualifies `done`: 1 = unsupported functype.

## Operation
- FSM states:
  - IDLE: `start` → capture op1/op2/functype, clear accumulator, beat counter and `illegal`. Next state is ISSUE for ALU ops, DONE otherwise.
  - ISSUE: assert `alu_valid` for exactly one cycle with the current beat's operands → WAIT.
  - WAIT: hold until `alu_rvalid`, then capture the beat. Last beat → DONE; otherwise increment beat and → ISSUE.
  - DONE: `done`=1 → IDLE.
- Beat k (0..3) covers lanes 4k..4k+3, i.e. bits [64k+63:64k].
- VADD: 4 beats, ADD. `alu_a`/`alu_b` = op1/op2 slice k. `alu_result` → `result[64k+63:64k]`.
- VDOT: 4 beats, MUL, same operand slicing. All four 16-bit products summed into a 16-bit accumulator, mod 2^16. `result` = {240'd0, acc}.
- SMUL: 4 beats, MUL. `alu_a` = op1[15:0] replicated ×4; `alu_b` = op2 slice k. Beat result → `result` slice k.
- VLD/VST: 1 beat, ADD on slice 0 (base + sign-extended offset as supplied by the picker). `result` = {240'd0, alu_result[15:0]}.
- SLL: no ALU. `result` = {240'd0, op1[15:8], op2[7:0]}.
- SLH: no ALU. `result` = {240'd0, op2[7:0], op1[7:0]}.
- NOP, SST: no ALU. `result` = 0.
- Any other functype: `result` = 0, `illegal`=1 with `done`.
- `alu_mode`, `alu_a`, `alu_b` are driven only while `alu_valid`=1; they are 0 otherwise.
- Boundary conditions:
  - `start` while `busy`=1: ignored, with no effect on captured state.
  - `alu_rvalid` outside WAIT: ignored.
  - `alu_rvalid` arriving in the same cycle as `alu_valid`: ignored, because the state is still ISSUE.
  - Reset mid-operation: return to IDLE. No `done` is produced, and any in-flight ALU response is dropped.

## Timing
- Reset values: state IDLE; `busy`, `done`, `alu_valid`, `illegal`, `alu_mode`, `alu_a`, `alu_b`, `result` all 0; accumulator and beat counter 0.
- `busy`, `done` and `alu_valid` are registered state decodes.
- Start sampled at T0. Latency below assumes ALU latency L=1:
  - VADD/VDOT/SMUL: beat issues at T1, T3, T5, T7; `done` at T9. In general `done` = T0 + 1 + 4(L+1).
  - VLD/VST: `done` at T0 + 2 + L.
  - Non-ALU ops: `done` at T1.
- A new `start` is accepted in the cycle after `done` (`busy`=0). Back-to-back issue interval is `done` latency + 1.
- `result` updates per beat during execution. Its value is guaranteed only from `done` onward.

## Test plan
- VADD, L=1: op1 lanes all 0x0001, op2 lane i = i → `result` lane i = i+1; `done` exactly 9 cycles after start; exactly 4 `alu_valid` pulses.
- VDOT: op1 lanes all 0x0002, op2 lane i = i → `result` = 0x00F0. Wrap case: op1 lanes all 0x1000, op2 lanes all 0x0001 → `result` = 0x0000.
- SMUL: op1[15:0] = 0x0003, op2 lane i = i → `result` lane i = 3i. Check `alu_a` = 0x0003000300030003 on every beat.
- VLD with L=3: op1[15:0] = 0x0100, op2[15:0] = 0xFFFE → `result` = 0x00FE, `done` at T5, one beat only. Early `alu_rvalid` injected during ISSUE is ignored.
- SLL: op1 = 0xAB12, op2 = 0x0034 → 0xAB34, `done` at T1. Functype 1010 → `illegal`=1 with `done`, `result` = 0. Second `start` while busy → no effect.
- Assert `rst_n`=0 after beat 1 of VADD → all outputs 0 immediately. Drive a late `alu_rvalid` after reset release → ignored, no `done`. A fresh VADD then completes correctly.
